booth4_pp_gen_pipe: RTL

//  Parametrised, pipelined radix-4 Booth partial-product generator for a WIDTH x WIDTH multiplier.

---
 rtl/booth4_pp_gen_pipe_if.sv | 31 +++
 rtl/booth4_pp_gen_pipe.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/booth4_pp_gen_pipe_if.sv
// Operand/result handshake bundle for the radix-4 Booth partial-product generator.
// The master side supplies operand pairs and consumes rows. The slave side is the generator.
interface booth4_pp_gen_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    localparam int NPP = WIDTH / 2 + 1;
    localparam int PPW = WIDTH + 2;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [NPP*PPW-1:0]   pp_rows;
    logic [TAG_W-1:0]     out_tag;
    logic [1:0]           occupancy;

    modport master (
        output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, pp_rows, out_tag, occupancy
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, pp_rows, out_tag, occupancy
    );
endinterface

// File: rtl/booth4_pp_gen_pipe.sv
// Two-stage radix-4 Booth partial-product generator with a valid/ready pipeline.
// Rows use inverted-sign encoding, so an all-zero digit yields 1 << (PPW-1).
module booth4_pp_gen_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    booth4_pp_gen_pipe_if.slave  bus
);
    localparam int NPP = WIDTH / 2 + 1;
    localparam int PPW = WIDTH + 2;

    // One row: select 0, +/-A or +/-2A from the Booth digit, then flip the sign bit.
    function automatic logic [PPW-1:0] booth_row(
        input logic [2:0]     sel,
        input logic [WIDTH:0] a,
        input logic [WIDTH:0] na
    );
        logic [PPW-1:0] v;
        case (sel)
            3'b001, 3'b010: v = {a[WIDTH], a};
            3'b011:         v = {a, 1'b0};
            3'b100:         v = {na, 1'b0};
            3'b101, 3'b110: v = {na[WIDTH], na};
            default:        v = {PPW{1'b0}};
        endcase
        return {~v[PPW-1], v[PPW-2:0]};
    endfunction

    logic                 s1_v_r;
    logic [WIDTH:0]       s1_a_r;
    logic [WIDTH:0]       s1_na_r;
    logic [WIDTH:0]       s1_b_r;
    logic                 s1_signed_r;
    logic [TAG_W-1:0]     s1_tag_r;
    logic                 s2_v_r;
    logic [NPP*PPW-1:0]   pp_rows_r;
    logic [TAG_W-1:0]     out_tag_r;
    logic [1:0]           occupancy_r;

    logic                 s2_adv_s;
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 s1_v_nxt_s;
    logic                 s2_v_nxt_s;
    logic [WIDTH:0]       a_ext_s;
    logic [WIDTH:0]       b_ext_s;
    logic [WIDTH+2:0]     b_win_s;
    logic [2:0]           sel_s;
    logic [NPP*PPW-1:0]   rows_s;

    // Handshake and next-state valid bits for both stages.
    always_comb begin
        s2_adv_s   = s1_v_r & (~s2_v_r | bus.out_ready);
        in_ready_s = ~s1_v_r | s2_adv_s;
        accept_s   = bus.in_valid & in_ready_s;
        if (accept_s) begin
            s1_v_nxt_s = 1'b1;
        end else if (s2_adv_s) begin
            s1_v_nxt_s = 1'b0;
        end else begin
            s1_v_nxt_s = s1_v_r;
        end
        if (s2_adv_s) begin
            s2_v_nxt_s = 1'b1;
        end else if (bus.out_ready) begin
            s2_v_nxt_s = 1'b0;
        end else begin
            s2_v_nxt_s = s2_v_r;
        end
    end

    // Operand extension; WIDTH+1 bits keeps -A of the most-negative A in range.
    always_comb begin
        a_ext_s = {bus.in_signed & bus.in_a[WIDTH-1], bus.in_a};
        b_ext_s = {bus.in_signed & bus.in_b[WIDTH-1], bus.in_b};
    end

    // Booth decode of stage 1 into all rows; window carries b[-1]=0 and b[WIDTH+1]=b[WIDTH].
    always_comb begin
        rows_s  = {(NPP*PPW){1'b0}};
        sel_s   = 3'b000;
        b_win_s = {s1_b_r[WIDTH], s1_b_r, 1'b0};
        for (int i = 0; i < NPP; i++) begin
            if (s1_signed_r && (i == NPP - 1)) begin
                sel_s = 3'b000;
            end else begin
                sel_s = b_win_s[2*i +: 3];
            end
            rows_s[i*PPW +: PPW] = booth_row(sel_s, s1_a_r, s1_na_r);
        end
    end

    // Stage 1 operand registers, loaded only on an accepted transfer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_v_r      <= 1'b0;
            s1_a_r      <= {(WIDTH+1){1'b0}};
            s1_na_r     <= {(WIDTH+1){1'b0}};
            s1_b_r      <= {(WIDTH+1){1'b0}};
            s1_signed_r <= 1'b0;
            s1_tag_r    <= {TAG_W{1'b0}};
        end else begin
            s1_v_r <= s1_v_nxt_s;
            if (accept_s) begin
                s1_a_r      <= a_ext_s;
                s1_na_r     <= -a_ext_s;
                s1_b_r      <= b_ext_s;
                s1_signed_r <= bus.in_signed;
                s1_tag_r    <= bus.in_tag;
            end else begin
                s1_a_r      <= s1_a_r;
                s1_na_r     <= s1_na_r;
                s1_b_r      <= s1_b_r;
                s1_signed_r <= s1_signed_r;
                s1_tag_r    <= s1_tag_r;
            end
        end
    end

    // Stage 2 output registers; data hold while the consumer stalls.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s2_v_r      <= 1'b0;
            pp_rows_r   <= {(NPP*PPW){1'b0}};
            out_tag_r   <= {TAG_W{1'b0}};
            occupancy_r <= 2'd0;
        end else begin
            s2_v_r      <= s2_v_nxt_s;
            occupancy_r <= {1'b0, s1_v_nxt_s} + {1'b0, s2_v_nxt_s};
            if (s2_adv_s) begin
                pp_rows_r <= rows_s;
                out_tag_r <= s1_tag_r;
            end else begin
                pp_rows_r <= pp_rows_r;
                out_tag_r <= out_tag_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_v_r;
    assign bus.pp_rows   = pp_rows_r;
    assign bus.out_tag   = out_tag_r;
    assign bus.occupancy = occupancy_r;
endmodule
